// File: rtl/call_stack_pkg.sv
// Shared constants for the PC path and the return-address stack,
// plus the encoding of the {push,pop} request pair.
package call_stack_pkg;

  localparam int unsigned PC_WIDTH    = 12;
  localparam int unsigned STACK_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } op_e;

endpackage

// File: rtl/call_stack_ram.sv
// DEPTH x WIDTH storage for the call stack: one synchronous write port,
// one asynchronous read port, contents are not reset.
module call_stack_ram #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Return-address stack: registered top-of-stack, occupancy count,
// full/empty status and sticky overflow/underflow flags.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH,
  parameter int unsigned DEPTH = STACK_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] stack_in,
  output logic [WIDTH-1:0] stack_out,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned CNT_W = PTR_W + 1;

  op_e              op;
  logic [CNT_W-1:0] count_n;
  logic [WIDTH-1:0] out_n;
  logic             ov_n;
  logic             uf_n;
  logic             we;
  logic [PTR_W-1:0] waddr;
  logic [PTR_W-1:0] raddr;
  logic [WIDTH-1:0] rdata_c;

  call_stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (stack_in),
    .raddr   (raddr),
    .rdata_c (rdata_c)
  );

  // Next-state decode; raddr always points at the entry below the top
  // so a pop can reload stack_out from it in the same cycle.
  always_comb begin
    op      = op_e'({push, pop});
    count_n = count;
    out_n   = stack_out;
    ov_n    = overflow;
    uf_n    = underflow;
    we      = 1'b0;
    waddr   = count[PTR_W-1:0];
    raddr   = PTR_W'(count - CNT_W'(2));
    case (op)
      OP_NOP: ;
      OP_PUSH: begin
        if (full) begin
          ov_n = 1'b1;
        end else begin
          we      = 1'b1;
          count_n = count + CNT_W'(1);
          out_n   = stack_in;
        end
      end
      OP_POP: begin
        if (empty) begin
          uf_n = 1'b1;
        end else begin
          count_n = count - CNT_W'(1);
          out_n   = (count == CNT_W'(1)) ? '0 : rdata_c;
        end
      end
      OP_REPLACE: begin
        we    = 1'b1;
        out_n = stack_in;
        if (empty) begin
          waddr   = '0;
          count_n = CNT_W'(1);
          uf_n    = 1'b1;
        end else begin
          waddr = PTR_W'(count - CNT_W'(1));
        end
      end
      default: ;
    endcase
  end

  // State and status registers; empty/full track count_n so they
  // always agree with the registered count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      stack_out <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_n;
      stack_out <= out_n;
      empty     <= (count_n == '0);
      full      <= (count_n == CNT_W'(DEPTH));
      overflow  <= ov_n;
      underflow <= uf_n;
    end
  end

endmodule
